// File: rtl/audio_ctrl_pkg.sv
// Shared types for the lab3 audio transport controller: state encoding,
// key index constants and the command-pulse bundle.
package audio_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        REC        = 3'd2,
        REC_PAUSE  = 3'd3,
        PLAY       = 3'd4,
        PLAY_PAUSE = 3'd5
    } ctrl_state_e;

    localparam int KEY_REC  = 0;
    localparam int KEY_PLAY = 1;
    localparam int KEY_STOP = 2;
    localparam int KEY_SPD  = 3;

    typedef struct packed {
        logic rec_start;
        logic rec_pause;
        logic rec_stop;
        logic play_start;
        logic play_pause;
        logic play_stop;
    } pulse_t;

endpackage

// File: rtl/audio_ctrl_if.sv
// Board-side signal bundle of the transport controller; master is the
// controller, slave is the board/recorder/DSP side.
interface audio_ctrl_if #(
    parameter int SPD_W = 4
);
    import audio_ctrl_pkg::*;

    logic [3:0]       i_key;
    logic             i_init_done;
    logic             i_rec_full;
    logic             i_play_end;
    logic             i_interp;
    ctrl_state_e      o_state;
    logic             o_rec_start;
    logic             o_rec_pause;
    logic             o_rec_stop;
    logic             o_play_start;
    logic             o_play_pause;
    logic             o_play_stop;
    logic             o_recording;
    logic             o_fast;
    logic             o_slow;
    logic             o_slow_lin;
    logic [SPD_W-1:0] o_speed;

    modport master (
        input  i_key, i_init_done, i_rec_full, i_play_end, i_interp,
        output o_state, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop,
               o_recording, o_fast, o_slow, o_slow_lin, o_speed
    );

    modport slave (
        output i_key, i_init_done, i_rec_full, i_play_end, i_interp,
        input  o_state, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop,
               o_recording, o_fast, o_slow, o_slow_lin, o_speed
    );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse when the accepted (active-low) level falls.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] count;
    logic             stable_done;

    assign stable_done = (count == CNT_W'(DEBOUNCE_CYCLES - 1));

    // count only consecutive samples that disagree with the accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync    <= 2'b11;
            count   <= '0;
            o_level <= 1'b1;
            o_press <= 1'b0;
        end else begin
            sync    <= {sync[0], i_key_n};
            o_press <= 1'b0;
            if (sync[1] == o_level) begin
                count <= '0;
            end else if (stable_done) begin
                count   <= '0;
                o_level <= sync[1];
                o_press <= o_level;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/audio_ctrl_fsm.sv
// Transport controller: debounced keys drive a record/play FSM with
// registered command pulses and a fast/slow playback speed selector.
module audio_ctrl_fsm
    import audio_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_SPEED       = 8,
    parameter int SPD_W           = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    audio_ctrl_if.master bus
);
    logic [3:0]       press;
    logic [3:0]       level;
    logic [3:0]       hit;
    logic             ev_stop, ev_rec, ev_play, ev_spd, spd_adv;
    ctrl_state_e      state, state_nxt;
    pulse_t           pulse, pulse_nxt;
    logic             recording;
    logic             fast, fast_nxt, slow, slow_nxt;
    logic [SPD_W-1:0] speed, speed_nxt;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_key_n (bus.i_key[k]),
            .o_level (level[k]),
            .o_press (press[k])
        );
    end

    // one key event per cycle: stop > rec > play > speed
    assign hit     = press & ~level;
    assign ev_stop = hit[KEY_STOP];
    assign ev_rec  = hit[KEY_REC]  & ~ev_stop;
    assign ev_play = hit[KEY_PLAY] & ~ev_stop & ~hit[KEY_REC];
    assign ev_spd  = hit[KEY_SPD]  & ~ev_stop & ~hit[KEY_REC] & ~hit[KEY_PLAY];

    always_comb begin
        state_nxt = state;
        pulse_nxt = '0;
        spd_adv   = 1'b0;
        case (state)
            INIT:       if (bus.i_init_done) state_nxt = IDLE;
            IDLE: begin
                if (ev_rec) begin
                    state_nxt = REC;  pulse_nxt.rec_start = 1'b1;
                end else if (ev_play) begin
                    state_nxt = PLAY; pulse_nxt.play_start = 1'b1;
                end
            end
            REC: begin
                if (bus.i_rec_full || ev_stop) begin
                    state_nxt = IDLE;      pulse_nxt.rec_stop = 1'b1;
                end else if (ev_rec) begin
                    state_nxt = REC_PAUSE; pulse_nxt.rec_pause = 1'b1;
                end
            end
            REC_PAUSE: begin
                if (ev_stop) begin
                    state_nxt = IDLE; pulse_nxt.rec_stop = 1'b1;
                end else if (ev_rec) begin
                    state_nxt = REC;  pulse_nxt.rec_start = 1'b1;
                end
            end
            PLAY: begin
                if (bus.i_play_end || ev_stop) begin
                    state_nxt = IDLE;       pulse_nxt.play_stop = 1'b1;
                end else if (ev_play) begin
                    state_nxt = PLAY_PAUSE; pulse_nxt.play_pause = 1'b1;
                end else begin
                    spd_adv = ev_spd;
                end
            end
            PLAY_PAUSE: begin
                if (ev_stop) begin
                    state_nxt = IDLE; pulse_nxt.play_stop = 1'b1;
                end else if (ev_play) begin
                    state_nxt = PLAY; pulse_nxt.play_start = 1'b1;
                end else begin
                    spd_adv = ev_spd;
                end
            end
            default:    state_nxt = INIT;
        endcase
    end

    // speed walks normal -> fast 2..MAX -> slow 2..MAX -> normal
    always_comb begin
        speed_nxt = speed;
        fast_nxt  = fast;
        slow_nxt  = slow;
        if (state_nxt == IDLE) begin
            speed_nxt = SPD_W'(1);
            fast_nxt  = 1'b0;
            slow_nxt  = 1'b0;
        end else if (spd_adv) begin
            if (!fast && !slow) begin
                speed_nxt = SPD_W'(2);
                fast_nxt  = 1'b1;
            end else if (speed == SPD_W'(MAX_SPEED)) begin
                speed_nxt = fast ? SPD_W'(2) : SPD_W'(1);
                slow_nxt  = fast;
                fast_nxt  = 1'b0;
            end else begin
                speed_nxt = speed + SPD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= INIT;
            pulse     <= '0;
            recording <= 1'b0;
            speed     <= SPD_W'(1);
            fast      <= 1'b0;
            slow      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse     <= pulse_nxt;
            recording <= (state_nxt == REC);
            speed     <= speed_nxt;
            fast      <= fast_nxt;
            slow      <= slow_nxt;
        end
    end

    assign bus.o_state      = state;
    assign bus.o_rec_start  = pulse.rec_start;
    assign bus.o_rec_pause  = pulse.rec_pause;
    assign bus.o_rec_stop   = pulse.rec_stop;
    assign bus.o_play_start = pulse.play_start;
    assign bus.o_play_pause = pulse.play_pause;
    assign bus.o_play_stop  = pulse.play_stop;
    assign bus.o_recording  = recording;
    assign bus.o_fast       = fast;
    assign bus.o_slow       = slow;
    assign bus.o_slow_lin   = slow & bus.i_interp;
    assign bus.o_speed      = speed;

endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// Directed bench for audio_ctrl_fsm with DEBOUNCE_CYCLES=4, MAX_SPEED=3.
module tb_audio_ctrl_fsm;
    import audio_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pcnt[6];
    int   base[6];
    int   viol = 0;
    int   exp_spd[5]  = '{2, 3, 2, 3, 1};
    int   exp_fast[5] = '{1, 1, 0, 0, 0};
    int   exp_slow[5] = '{0, 0, 1, 1, 0};

    audio_ctrl_if #(.SPD_W(4)) bus ();

    audio_ctrl_fsm #(.DEBOUNCE_CYCLES(4), .MAX_SPEED(3), .SPD_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic press_keys(input logic [3:0] mask);
        bus.i_key = bus.i_key & ~mask;
        repeat (10) @(negedge clk);
        bus.i_key = bus.i_key | mask;
        repeat (10) @(negedge clk);
    endtask

    // pulse counters and per-cycle invariants, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (bus.o_rec_start)  pcnt[0]++;
        if (bus.o_rec_pause)  pcnt[1]++;
        if (bus.o_rec_stop)   pcnt[2]++;
        if (bus.o_play_start) pcnt[3]++;
        if (bus.o_play_pause) pcnt[4]++;
        if (bus.o_play_stop)  pcnt[5]++;
        if ($countones({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                        bus.o_play_start, bus.o_play_pause, bus.o_play_stop}) > 1 ||
            bus.o_recording !== (bus.o_state == REC) || (bus.o_fast && bus.o_slow))
            viol++;
    end

    initial begin
        bus.i_key = 4'hF;
        bus.i_init_done = 1'b0;
        bus.i_rec_full = 1'b0;
        bus.i_play_end = 1'b0;
        bus.i_interp = 1'b1;

        @(negedge clk);
        chk("rst_state", bus.o_state, INIT);
        chk("rst_speed", bus.o_speed, 1);
        chk("rst_outs", {bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop, bus.o_play_start,
                         bus.o_play_pause, bus.o_play_stop, bus.o_recording, bus.o_fast,
                         bus.o_slow, bus.o_slow_lin}, 0);
        rst_n = 1'b1;

        // keys ignored in INIT
        base = pcnt;
        press_keys(4'b0010);
        chk("init_keys_state", bus.o_state, INIT);
        chk("init_keys_pulse", pcnt[3] - base[3], 0);
        bus.i_init_done = 1'b1;
        @(negedge clk);
        chk("init_to_idle", bus.o_state, IDLE);

        // bouncing rec key
        base = pcnt;
        for (int i = 0; i < 10; i++) begin
            bus.i_key[0] = ~bus.i_key[0];
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_event", bus.o_state, IDLE);
        press_keys(4'b0001);
        chk("bounce_rec_start", pcnt[0] - base[0], 1);
        chk("bounce_state", bus.o_state, REC);
        chk("bounce_recording", bus.o_recording, 1);

        // pause / resume / memory full
        base = pcnt;
        press_keys(4'b0001);
        chk("rec_pause_state", bus.o_state, REC_PAUSE);
        chk("rec_pause_cnt", pcnt[1] - base[1], 1);
        chk("rec_pause_recording", bus.o_recording, 0);
        press_keys(4'b0001);
        chk("rec_resume_state", bus.o_state, REC);
        chk("rec_resume_cnt", pcnt[0] - base[0], 1);
        bus.i_rec_full = 1'b1;
        @(negedge clk);
        chk("rec_full_state", bus.o_state, IDLE);
        chk("rec_full_pulse", bus.o_rec_stop, 1);
        bus.i_rec_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rec_stop_cnt", pcnt[2] - base[2], 1);

        // speed sequence in PLAY
        base = pcnt;
        press_keys(4'b0010);
        chk("play_state", bus.o_state, PLAY);
        chk("play_start_cnt", pcnt[3] - base[3], 1);
        for (int i = 0; i < 5; i++) begin
            press_keys(4'b1000);
            chk($sformatf("spd%0d_speed", i), bus.o_speed, exp_spd[i]);
            chk($sformatf("spd%0d_fast", i), bus.o_fast, exp_fast[i]);
            chk($sformatf("spd%0d_slow", i), bus.o_slow, exp_slow[i]);
            chk($sformatf("spd%0d_slow_lin", i), bus.o_slow_lin, exp_slow[i]);
        end

        // speed persists across pause; stop beats play in the same cycle
        press_keys(4'b1000);
        press_keys(4'b0010);
        chk("pp_state", bus.o_state, PLAY_PAUSE);
        chk("pp_speed_kept", bus.o_speed, 2);
        base = pcnt;
        press_keys(4'b0110);
        chk("prio_state", bus.o_state, IDLE);
        chk("prio_play_stop", pcnt[5] - base[5], 1);
        chk("prio_no_play_start", pcnt[3] - base[3], 0);
        chk("prio_speed_clear", bus.o_speed, 1);

        // end of playback
        press_keys(4'b0010);
        press_keys(4'b1000);
        chk("ae_fast_before", bus.o_fast, 1);
        base = pcnt;
        bus.i_play_end = 1'b1;
        @(negedge clk);
        chk("ae_state", bus.o_state, IDLE);
        chk("ae_pulse", bus.o_play_stop, 1);
        chk("ae_fast_slow", {bus.o_fast, bus.o_slow}, 0);
        chk("ae_speed", bus.o_speed, 1);
        bus.i_play_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("ae_stop_cnt", pcnt[5] - base[5], 1);

        // asynchronous reset mid-record
        press_keys(4'b0001);
        chk("ar_in_rec", bus.o_state, REC);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", bus.o_state, INIT);
        chk("ar_recording", bus.o_recording, 0);
        chk("ar_pulses", {bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                          bus.o_play_start, bus.o_play_pause, bus.o_play_stop}, 0);
        bus.i_init_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_hold_init", bus.o_state, INIT);
        bus.i_init_done = 1'b1;
        @(negedge clk);
        chk("ar_to_idle", bus.o_state, IDLE);

        chk("invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
